piradip_axis_iq_interleaver: RTL and testbench
==============================================

PIRADIP_AXIS_IQ_INTERLEAVER -- requirements
Module: piradip_axis_iq_interleaver

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16: bits per I or Q sample.
REQ-002 SHALL have parameter N_SAMPLES, default 4: samples per input beat, minimum 1.
REQ-003 SHALL have parameter Q_FIRST, default 1: 1 places Q in the lower half of each output IQ pair; 0 places I in the lower half.
REQ-004 SHALL have parameter COUNT_WIDTH, default 32: width of the output beat counter.
REQ-005 SHALL have port aclk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port aresetn, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port I_in, axi4s.SUBORDINATE, tdata N_SAMPLES*SAMPLE_WIDTH: I sample stream with tvalid/tready/tlast.
REQ-008 SHALL have port Q_in, axi4s.SUBORDINATE, tdata N_SAMPLES*SAMPLE_WIDTH: Q sample stream with tvalid/tready/tlast.
REQ-009 SHALL have port IQ_out, axi4s.MANAGER, tdata 2*N_SAMPLES*SAMPLE_WIDTH: interleaved IQ stream with tvalid/tready/tlast.
REQ-010 SHALL have port clear_err, input, 1: synchronous clear of tlast_mismatch.
REQ-011 SHALL have port tlast_mismatch, output, 1: sticky flag, set when paired I/Q beats disagree on tlast.
REQ-012 SHALL have port beat_count, output, COUNT_WIDTH: number of IQ_out beats transferred since reset.

Function
REQ-013 SHALL give each input a 2-entry skid buffer, so that each input's tready depends only on that input's own buffer occupancy and never combinationally on IQ_out.tready or on the other input.
REQ-014 SHALL drive I_in.tready high exactly when the I buffer holds fewer than 2 entries; Q_in.tready SHALL follow the same rule on the Q buffer.
REQ-015 SHALL pair beats in strict arrival order: the k-th accepted I beat SHALL always be paired with the k-th accepted Q beat.
REQ-016 SHALL perform a join when both buffers are non-empty and the output register is empty or is being consumed in the same cycle (IQ_out.tvalid && IQ_out.tready).
REQ-017 SHALL, on a join, pop one entry from each buffer and load the output register in the same cycle.
REQ-018 SHALL, for Q_FIRST=1 and each n in 0..N_SAMPLES-1, place Q sample n at output slot 2n and I sample n at slot 2n+1; slot s occupies bits [s*SAMPLE_WIDTH +: SAMPLE_WIDTH].
REQ-019 SHALL swap the I and Q slot assignments of REQ-018 when Q_FIRST=0.
REQ-020 SHALL drive IQ_out.tlast from the I beat's tlast of the joined pair.
REQ-021 SHALL set tlast_mismatch on any join where the I and Q tlast values differ; the flag SHALL stay set until clear_err is sampled high.
REQ-022 SHALL give a set event priority over clear_err when both occur in the same cycle.
REQ-023 SHALL hold IQ_out.tvalid, tdata and tlast stable while tvalid=1 and tready=0.
REQ-024 SHALL make data accepted on both inputs in cycle t, with both buffers empty and the output register empty, appear on IQ_out in cycle t+2, given one cycle in the skid buffer and one in the output register.
REQ-025 SHALL sustain one output beat per cycle when both inputs are valid and IQ_out.tready is held at 1.
REQ-026 SHALL increment beat_count on each IQ_out transfer and wrap modulo 2^COUNT_WIDTH.
REQ-027 SHALL fail an elaboration-time assertion if I_in, Q_in or IQ_out widths do not match REQ-007 to REQ-009.

Reset
REQ-028 SHALL, while aresetn=0, empty both buffers and drive IQ_out.tvalid=0, IQ_out.tlast=0, IQ_out.tdata=0, tlast_mismatch=0 and beat_count=0.
REQ-029 SHALL hold I_in.tready=0 and Q_in.tready=0 while aresetn=0, and raise both in the first cycle after release.
REQ-030 SHALL discard all buffered and in-flight beats when reset asserts mid-stream, with no partial beat emitted after release.

Verification
REQ-031 SHALL pass this scenario: N_SAMPLES=2, Q_FIRST=1, I={0x0002,0x0001}, Q={0x0004,0x0003}, tready=1 -> IQ_out.tdata=0x0002_0004_0001_0003, two cycles after acceptance.
REQ-032 SHALL pass this scenario: same data with Q_FIRST=0 -> IQ_out.tdata=0x0004_0002_0003_0001.
REQ-033 SHALL pass this scenario: I stream valid 8 cycles before Q starts -> I_in.tready drops after 2 beats, Q_in.tready stays 1, and outputs pair I0/Q0 through I7/Q7 in order.
REQ-034 SHALL pass this scenario: 100 beats, random tvalid on both inputs, random IQ_out.tready -> all 100 beats out in order, no loss or duplication, beat_count=100, and tdata stable under every stall.
REQ-035 SHALL pass this scenario: I tlast=1 paired with Q tlast=0 -> IQ_out.tlast=1 and tlast_mismatch=1, which persists until clear_err=1, then returns to 0.
REQ-036 SHALL pass this scenario: aresetn pulsed low with 2 I beats buffered and an output beat stalled -> tvalid=0, beat_count=0, and the first post-reset output is the first post-reset pair.

Source files
------------

// File: rtl/piradip_axis_iq_interleaver.sv
// -----------------------------------------------------------------------------
// piradip_axis_iq_interleaver
//
// Purpose
//   Joins an AXI4-Stream of I samples and an AXI4-Stream of Q samples into a
//   single interleaved IQ stream. Each input beat carries N_SAMPLES samples of
//   SAMPLE_WIDTH bits; each output beat carries the N_SAMPLES matching I/Q
//   pairs. Beats are paired strictly in arrival order: the k-th accepted I beat
//   is always joined with the k-th accepted Q beat.
//
//   Each input lands in its own 2-entry skid buffer. An input's tready depends
//   only on that input's buffer occupancy, never combinationally on
//   IQ_out_tready or on the other input. A join pops one entry from each
//   buffer and loads the registered output stage in the same cycle, so the
//   latency from an input handshake to IQ_out_tvalid is two cycles when the
//   pipe is idle. Throughput is one beat per cycle.
//
// Parameters
//   SAMPLE_WIDTH : bits per I or Q sample
//   N_SAMPLES    : samples per input beat (>= 1)
//   Q_FIRST      : 1 -> Q in the lower half of each output pair, 0 -> I lower
//   COUNT_WIDTH  : width of the output beat counter (wraps)
//
// Ports
//   aclk, aresetn         : clock, asynchronous active-low reset
//   I_in_t*               : I subordinate stream (tdata/tvalid/tready/tlast)
//   Q_in_t*               : Q subordinate stream (tdata/tvalid/tready/tlast)
//   IQ_out_t*             : interleaved manager stream, tdata 2x input width
//   clear_err             : synchronous clear of tlast_mismatch
//   tlast_mismatch        : sticky, set when a joined pair disagrees on tlast
//   beat_count            : IQ_out transfers since reset, modulo 2^COUNT_WIDTH
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// piradip_axis_iq_skid2
//
// Two-entry FIFO used as the input skid buffer of one stream.
//   enable_i            : gates s_tready_o; low until the first clock after reset
//   s_t*_i / s_tready_o : upstream AXI4-Stream side
//   m_tdata_o/m_tlast_o : head entry (valid while m_valid_o is high)
//   m_valid_o           : buffer non-empty
//   pop_i               : remove the head entry (only when m_valid_o is high)
// -----------------------------------------------------------------------------
module piradip_axis_iq_skid2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tlast_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tlast_o,
  output logic                  m_valid_o,
  input  logic                  pop_i
);

  // Storage is {tlast, tdata}; contents need no reset because occupancy
  // alone decides whether an entry is meaningful.
  logic [DATA_WIDTH:0] mem_q [2];
  logic [1:0]          count_q, count_d;
  logic                wr_ptr_q, rd_ptr_q;
  logic                push;

  // Ready comes only from registered state of this buffer.
  assign s_tready_o = enable_i && (count_q != 2'd2);
  assign push       = s_tvalid_i && s_tready_o;
  assign m_valid_o  = (count_q != 2'd0);
  assign m_tdata_o  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign m_tlast_o  = mem_q[rd_ptr_q][DATA_WIDTH];

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop_i};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_tlast_i, s_tdata_i};
    end
  end

endmodule

// -----------------------------------------------------------------------------
// Top level
// -----------------------------------------------------------------------------
module piradip_axis_iq_interleaver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int N_SAMPLES    = 4,
  parameter int Q_FIRST      = 1,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  // I stream (subordinate)
  input  logic [N_SAMPLES*SAMPLE_WIDTH-1:0]   I_in_tdata,
  input  logic                                I_in_tvalid,
  output logic                                I_in_tready,
  input  logic                                I_in_tlast,
  // Q stream (subordinate)
  input  logic [N_SAMPLES*SAMPLE_WIDTH-1:0]   Q_in_tdata,
  input  logic                                Q_in_tvalid,
  output logic                                Q_in_tready,
  input  logic                                Q_in_tlast,
  // Interleaved IQ stream (manager)
  output logic [2*N_SAMPLES*SAMPLE_WIDTH-1:0] IQ_out_tdata,
  output logic                                IQ_out_tvalid,
  input  logic                                IQ_out_tready,
  output logic                                IQ_out_tlast,
  // Status
  input  logic                                clear_err,
  output logic                                tlast_mismatch,
  output logic [COUNT_WIDTH-1:0]              beat_count
);

  localparam int IN_W  = N_SAMPLES * SAMPLE_WIDTH;
  localparam int OUT_W = 2 * IN_W;

  // ---------------------------------------------------------------------------
  // Elaboration-time sanity checks on configuration and port widths.
  // ---------------------------------------------------------------------------
  if (N_SAMPLES < 1) begin : g_bad_n_samples
    $error("piradip_axis_iq_interleaver: N_SAMPLES must be at least 1");
  end
  if (($bits(I_in_tdata) != IN_W) || ($bits(Q_in_tdata) != IN_W) ||
      ($bits(IQ_out_tdata) != OUT_W)) begin : g_bad_widths
    $error("piradip_axis_iq_interleaver: stream tdata widths inconsistent");
  end

  // ---------------------------------------------------------------------------
  // Readiness enable: keeps both treadys low during reset and raises them on
  // the first clock edge after release, without routing aresetn into logic.
  // ---------------------------------------------------------------------------
  logic run_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Input skid buffers
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0] i_head_data, q_head_data;
  logic            i_head_last, q_head_last;
  logic            i_head_valid, q_head_valid;
  logic            do_join;

  piradip_axis_iq_skid2 #(.DATA_WIDTH(IN_W)) u_i_skid (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .enable_i   (run_q),
    .s_tdata_i  (I_in_tdata),
    .s_tlast_i  (I_in_tlast),
    .s_tvalid_i (I_in_tvalid),
    .s_tready_o (I_in_tready),
    .m_tdata_o  (i_head_data),
    .m_tlast_o  (i_head_last),
    .m_valid_o  (i_head_valid),
    .pop_i      (do_join)
  );

  piradip_axis_iq_skid2 #(.DATA_WIDTH(IN_W)) u_q_skid (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .enable_i   (run_q),
    .s_tdata_i  (Q_in_tdata),
    .s_tlast_i  (Q_in_tlast),
    .s_tvalid_i (Q_in_tvalid),
    .s_tready_o (Q_in_tready),
    .m_tdata_o  (q_head_data),
    .m_tlast_o  (q_head_last),
    .m_valid_o  (q_head_valid),
    .pop_i      (do_join)
  );

  // ---------------------------------------------------------------------------
  // Sample interleaving: pair n occupies slots 2n (low) and 2n+1 (high).
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] joined_data;

  for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_pair
    if (Q_FIRST != 0) begin : g_q_low
      assign joined_data[(2*gi)*SAMPLE_WIDTH +: SAMPLE_WIDTH]   =
        q_head_data[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      assign joined_data[(2*gi+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
        i_head_data[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end else begin : g_i_low
      assign joined_data[(2*gi)*SAMPLE_WIDTH +: SAMPLE_WIDTH]   =
        i_head_data[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      assign joined_data[(2*gi+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
        q_head_data[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Output register, error flag and beat counter
  // ---------------------------------------------------------------------------
  logic                   out_valid_q, out_valid_d;
  logic [OUT_W-1:0]       out_data_q,  out_data_d;
  logic                   out_last_q,  out_last_d;
  logic                   mismatch_q,  mismatch_d;
  logic [COUNT_WIDTH-1:0] count_q,     count_d;
  logic                   out_xfer;

  assign out_xfer = out_valid_q && IQ_out_tready;

  // A join needs both heads present and a free (or freeing) output slot.
  // Because loads only happen on a join, a stalled beat can never be
  // overwritten, which keeps tdata/tlast stable under backpressure.
  assign do_join = i_head_valid && q_head_valid && (!out_valid_q || IQ_out_tready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (do_join) begin
      out_valid_d = 1'b1;
      out_data_d  = joined_data;
      out_last_d  = i_head_last;
    end else if (IQ_out_tready) begin
      out_valid_d = 1'b0;
    end

    // Setting wins over clearing when both happen in the same cycle.
    mismatch_d = mismatch_q;
    if (do_join && (i_head_last != q_head_last)) begin
      mismatch_d = 1'b1;
    end else if (clear_err) begin
      mismatch_d = 1'b0;
    end

    count_d = count_q + COUNT_WIDTH'(out_xfer);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      mismatch_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      mismatch_q  <= mismatch_d;
      count_q     <= count_d;
    end
  end

  assign IQ_out_tvalid  = out_valid_q;
  assign IQ_out_tdata   = out_data_q;
  assign IQ_out_tlast   = out_last_q;
  assign tlast_mismatch = mismatch_q;
  assign beat_count     = count_q;

endmodule

// File: tb/tb_piradip_axis_iq_interleaver.sv
// -----------------------------------------------------------------------------
// Testbench for piradip_axis_iq_interleaver. Two instances share all inputs:
// dut0 uses Q_FIRST=1, dut1 uses Q_FIRST=0, both with N_SAMPLES=2,
// SAMPLE_WIDTH=16 and an 8-bit beat counter so wrap-around is reachable.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_piradip_axis_iq_interleaver;

  localparam int W  = 16;
  localparam int N  = 2;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic [31:0] i_tdata, q_tdata;
  logic        i_tvalid, i_tlast, q_tvalid, q_tlast, out_tready, clear_err;

  logic        i_tready0, q_tready0, o_tvalid0, o_tlast0, mism0;
  logic [63:0] o_tdata0;
  logic [7:0]  cnt0;
  logic        i_tready1, q_tready1, o_tvalid1, o_tlast1, mism1;
  logic [63:0] o_tdata1;
  logic [7:0]  cnt1;

  piradip_axis_iq_interleaver #(
    .SAMPLE_WIDTH(W), .N_SAMPLES(N), .Q_FIRST(1), .COUNT_WIDTH(CW)
  ) dut0 (
    .aclk(clk), .aresetn(aresetn),
    .I_in_tdata(i_tdata), .I_in_tvalid(i_tvalid), .I_in_tready(i_tready0), .I_in_tlast(i_tlast),
    .Q_in_tdata(q_tdata), .Q_in_tvalid(q_tvalid), .Q_in_tready(q_tready0), .Q_in_tlast(q_tlast),
    .IQ_out_tdata(o_tdata0), .IQ_out_tvalid(o_tvalid0), .IQ_out_tready(out_tready),
    .IQ_out_tlast(o_tlast0), .clear_err(clear_err), .tlast_mismatch(mism0), .beat_count(cnt0)
  );

  piradip_axis_iq_interleaver #(
    .SAMPLE_WIDTH(W), .N_SAMPLES(N), .Q_FIRST(0), .COUNT_WIDTH(CW)
  ) dut1 (
    .aclk(clk), .aresetn(aresetn),
    .I_in_tdata(i_tdata), .I_in_tvalid(i_tvalid), .I_in_tready(i_tready1), .I_in_tlast(i_tlast),
    .Q_in_tdata(q_tdata), .Q_in_tvalid(q_tvalid), .Q_in_tready(q_tready1), .Q_in_tlast(q_tlast),
    .IQ_out_tdata(o_tdata1), .IQ_out_tvalid(o_tvalid1), .IQ_out_tready(out_tready),
    .IQ_out_tlast(o_tlast1), .clear_err(clear_err), .tlast_mismatch(mism1), .beat_count(cnt1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: queues of accepted beats, paired in order, interleaved
  // by the slot rule (pair n: low slot 2n, high slot 2n+1).
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [63:0] d0;
    logic [63:0] d1;
    logic        last;
  } exp_t;

  logic [32:0] mi_q[$];
  logic [32:0] mq_q[$];
  exp_t        exp_q[$];

  function automatic logic [63:0] interleave(input logic [31:0] iv, input logic [31:0] qv,
                                             input bit qfirst);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < N; n++) begin
      if (qfirst) begin
        r[(2*n)*W +: W]   = qv[n*W +: W];
        r[(2*n+1)*W +: W] = iv[n*W +: W];
      end else begin
        r[(2*n)*W +: W]   = iv[n*W +: W];
        r[(2*n+1)*W +: W] = qv[n*W +: W];
      end
    end
    return r;
  endfunction

  task automatic pair_model();
    logic [32:0] a, b;
    exp_t        e;
    while (mi_q.size() > 0 && mq_q.size() > 0) begin
      a      = mi_q.pop_front();
      b      = mq_q.pop_front();
      e.d0   = interleave(a[31:0], b[31:0], 1'b1);
      e.d1   = interleave(a[31:0], b[31:0], 1'b0);
      e.last = a[32];
      exp_q.push_back(e);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] iv;
    logic [31:0] qv;
    logic        il;
    logic        ql;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;

  vec_t vecs[4];

  // One pair accepted in cycle t with an idle pipe must appear at t+2.
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    i_tdata = v.iv; i_tlast = v.il; i_tvalid = 1'b1;
    q_tdata = v.qv; q_tlast = v.ql; q_tvalid = 1'b1;
    out_tready = 1'b1;
    #1;
    chk($sformatf("vec%0d_in_ready", idx), {62'd0, i_tready0, q_tready0}, 64'd3);
    @(negedge clk);
    i_tvalid = 1'b0; q_tvalid = 1'b0;
    chk($sformatf("vec%0d_t1_valid", idx), o_tvalid0, 1'b0);
    @(negedge clk);
    chk($sformatf("vec%0d_t2_valid", idx), o_tvalid0, 1'b1);
    chk($sformatf("vec%0d_data_qfirst", idx), o_tdata0, v.e0);
    chk($sformatf("vec%0d_data_ifirst", idx), o_tdata1, v.e1);
    chk($sformatf("vec%0d_tlast", idx), o_tlast0, v.il);
    @(negedge clk);
    chk($sformatf("vec%0d_drained", idx), o_tvalid0, 1'b0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    aresetn = 1'b0;
    i_tvalid = 1'b0; q_tvalid = 1'b0; out_tready = 1'b0; clear_err = 1'b0;
    i_tlast = 1'b0; q_tlast = 1'b0; i_tdata = '0; q_tdata = '0;
    #1;
    chk("rst_tvalid", o_tvalid0, 1'b0);
    chk("rst_tdata", o_tdata0, 64'd0);
    chk("rst_tlast", o_tlast0, 1'b0);
    chk("rst_mismatch", mism0, 1'b0);
    chk("rst_count", cnt0, 8'd0);
    chk("rst_tready", {62'd0, i_tready0, q_tready0}, 64'd0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", {62'd0, i_tready0, q_tready0}, 64'd3);
    mi_q.delete(); mq_q.delete(); exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Randomised streaming against the model. q_lead delays the Q source.
  // ---------------------------------------------------------------------------
  task automatic run_stream(input int nbeats, input int q_lead, input int pv,
                            input int pr, input bit chk_lead);
    int          i_sent, q_sent, got, cyc;
    bit          i_hold, q_hold, stalled;
    logic [63:0] held;
    bit          last_arr[];
    exp_t        e;
    last_arr = new[nbeats];
    for (int k = 0; k < nbeats; k++) last_arr[k] = ($urandom_range(0, 3) == 0);
    i_sent = 0; q_sent = 0; got = 0; cyc = 0;
    i_hold = 0; q_hold = 0; stalled = 0; held = '0;
    while (got < nbeats && cyc < 5000) begin
      @(negedge clk);
      if (!i_hold) begin
        if (i_sent < nbeats && $urandom_range(0, 99) < pv) begin
          i_tvalid = 1'b1; i_tdata = $urandom; i_tlast = last_arr[i_sent]; i_hold = 1;
        end else begin
          i_tvalid = 1'b0;
        end
      end
      if (!q_hold) begin
        if (cyc >= q_lead && q_sent < nbeats && $urandom_range(0, 99) < pv) begin
          q_tvalid = 1'b1; q_tdata = $urandom; q_tlast = last_arr[q_sent]; q_hold = 1;
        end else begin
          q_tvalid = 1'b0;
        end
      end
      out_tready = ($urandom_range(0, 99) < pr);
      #1;
      if (chk_lead && cyc >= 2 && cyc < q_lead) begin
        chk("lead_i_tready", i_tready0, 1'b0);
        chk("lead_q_tready", q_tready0, 1'b1);
      end
      if (stalled) begin
        chk("stall_valid", o_tvalid0, 1'b1);
        chk("stall_data", o_tdata0, held);
      end
      stalled = o_tvalid0 && !out_tready;
      held    = o_tdata0;
      if (o_tvalid0 && out_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stream_extra_beat actual=%h required=none", o_tdata0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_data_qfirst", o_tdata0, e.d0);
          chk("stream_data_ifirst", o_tdata1, e.d1);
          chk("stream_tlast", o_tlast0, e.last);
        end
        got++;
      end
      if (i_tvalid && i_tready0) begin
        mi_q.push_back({i_tlast, i_tdata}); i_sent++; i_hold = 0;
      end
      if (q_tvalid && q_tready0) begin
        mq_q.push_back({q_tlast, q_tdata}); q_sent++; q_hold = 0;
      end
      pair_model();
      cyc++;
    end
    chk("stream_beats_out", 64'(got), 64'(nbeats));
    @(negedge clk);
    i_tvalid = 1'b0; q_tvalid = 1'b0; out_tready = 1'b1;
    @(negedge clk);
    chk("stream_no_leftover", o_tvalid0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    vecs[0] = '{32'h0002_0001, 32'h0004_0003, 1'b0, 1'b0,
                64'h0002_0004_0001_0003, 64'h0004_0002_0003_0001};
    vecs[1] = '{32'hffff_0000, 32'h1234_abcd, 1'b0, 1'b0,
                64'hffff_1234_0000_abcd, 64'h1234_ffff_abcd_0000};
    vecs[2] = '{32'hdead_beef, 32'hcafe_f00d, 1'b1, 1'b1,
                64'hdead_cafe_beef_f00d, 64'hcafe_dead_f00d_beef};
    vecs[3] = '{32'h8000_7fff, 32'h0001_fffe, 1'b0, 1'b0,
                64'h8000_0001_7fff_fffe, 64'h0001_8000_fffe_7fff};

    reset_dut();

    for (int v = 0; v < 4; v++) apply_vec(vecs[v], v);
    chk("vec_count", cnt0, 8'd4);
    chk("vec_no_mismatch", mism0, 1'b0);

    // tlast disagreement; clear_err in the join cycle must lose to the set.
    @(negedge clk);
    i_tdata = 32'h0a0a_0b0b; i_tlast = 1'b1; i_tvalid = 1'b1;
    q_tdata = 32'h0c0c_0d0d; q_tlast = 1'b0; q_tvalid = 1'b1;
    out_tready = 1'b1;
    @(negedge clk);
    i_tvalid = 1'b0; q_tvalid = 1'b0; clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("mm_out_tlast", o_tlast0, 1'b1);
    chk("mm_flag_set_priority", mism0, 1'b1);
    chk("mm_flag_set_ifirst", mism1, 1'b1);
    repeat (3) @(negedge clk);
    chk("mm_flag_sticky", mism0, 1'b1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("mm_flag_cleared", mism0, 1'b0);

    // I leads Q by 8 cycles.
    run_stream(8, 8, 100, 100, 1'b1);

    // Reset with an output beat stalled and two I beats buffered.
    @(negedge clk);
    out_tready = 1'b0;
    i_tdata = 32'h1111_2222; i_tlast = 1'b0; i_tvalid = 1'b1;
    q_tdata = 32'h3333_4444; q_tlast = 1'b0; q_tvalid = 1'b1;
    @(negedge clk);
    q_tvalid = 1'b0; i_tdata = 32'h5555_6666;
    @(negedge clk);
    i_tdata = 32'h7777_8888;
    @(negedge clk);
    i_tvalid = 1'b0;
    #1;
    chk("pre_rst_stalled", o_tvalid0, 1'b1);
    chk("pre_rst_i_full", i_tready0, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("async_rst_tvalid", o_tvalid0, 1'b0);
    chk("async_rst_count", cnt0, 8'd0);
    chk("async_rst_tready", i_tready0, 1'b0);
    reset_dut();
    apply_vec(vecs[1], 10);
    chk("post_rst_count", cnt0, 8'd1);

    // 100 random beats from a clean reset, then wrap the 8-bit counter.
    reset_dut();
    run_stream(100, 0, 60, 60, 1'b0);
    chk("count_100", cnt0, 8'd100);
    chk("stream_no_mismatch", mism0, 1'b0);
    run_stream(200, 0, 80, 70, 1'b0);
    chk("count_wrap", cnt0, 8'd44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
